// File: rtl/lc3b_types.sv
// Shared LC-3b memory-path types: word/line widths and the arbiter grant encoding.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   function automatic grant_e other_grant(input grant_e g);
      return (g == GRANT_I) ? GRANT_D : GRANT_I;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting the icache and dcache on one physical memory port.
// pmem command starts 1 cycle after the request; requests wait in IDLE while memory is busy.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter bit FIRST_D = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,

   input  logic     i_read,
   input  lc3b_word i_address,
   output lc3b_line i_rdata,
   output logic     i_resp,

   input  logic     d_read,
   input  logic     d_write,
   input  lc3b_word d_address,
   input  lc3b_line d_wdata,
   output lc3b_line d_rdata,
   output logic     d_resp,

   output logic     pmem_read,
   output logic     pmem_write,
   output lc3b_word pmem_address,
   output lc3b_line pmem_wdata,
   input  lc3b_line pmem_rdata,
   input  logic     pmem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_e;

   state_e   state;
   state_e   state_nxt;
   grant_e   last_grant;
   grant_e   winner;
   logic     i_req;
   logic     d_req;
   logic     load;
   logic     done;

   lc3b_word addr_q;
   lc3b_line wdata_q;
   logic     rd_q;
   logic     wr_q;

   // Next-state and response logic. Responses are gated by rst_n so a reset
   // landing on the completion cycle swallows the pulse.
   always_comb begin
      i_req     = i_read;
      d_req     = d_read | d_write;
      winner    = GRANT_I;
      state_nxt = state;
      load      = 1'b0;
      done      = 1'b0;

      if (i_req && d_req) begin
         winner = other_grant(last_grant);
      end else if (d_req) begin
         winner = GRANT_D;
      end

      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               load      = 1'b1;
               state_nxt = (winner == GRANT_D) ? SERVE_D : SERVE_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      i_resp  = rst_n && (state == SERVE_I) && pmem_resp;
      d_resp  = rst_n && (state == SERVE_D) && pmem_resp;
      i_rdata = i_resp ? pmem_rdata : '0;
      d_rdata = d_resp ? pmem_rdata : '0;
   end

   // Transaction latch: the winner's request is frozen here so later changes
   // on the cache side cannot disturb an in-flight memory access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= FIRST_D ? GRANT_I : GRANT_D;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            last_grant <= winner;
            if (winner == GRANT_D) begin
               addr_q  <= d_address;
               wdata_q <= d_wdata;
               wr_q    <= d_write;
               rd_q    <= ~d_write;
            end else begin
               addr_q  <= i_address;
               rd_q    <= 1'b1;
               wr_q    <= 1'b0;
            end
         end else if (done) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
         end
      end
   end

   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model, memory responder, cache agents, directed scenarios.
module tb_mem_arbiter;
   import lc3b_types::*;

   localparam bit FIRST_D = 1'b1;

   logic     clk = 1'b0;
   logic     rst_n;
   logic     i_read, d_read, d_write, i_resp, d_resp;
   lc3b_word i_address, d_address, pmem_address;
   lc3b_line i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
   logic     pmem_read, pmem_write, pmem_resp;

   mem_arbiter #(.FIRST_D(FIRST_D)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic lc3b_line line_of(input lc3b_word a);
      return {a, ~a, a + 16'd1, a ^ 16'hA5A5, a, ~a, a + 16'd2, 16'h1234};
   endfunction

   always @(posedge clk) cyc++;

   // Physical memory: responds once a command has been held for mem_lat cycles.
   int mem_lat = 3;
   int mem_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (pmem_read || pmem_write) begin
         if (mem_cnt == mem_lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = line_of(pmem_address);
         end else begin
            pmem_resp = 1'b0;
         end
         mem_cnt++;
      end else begin
         pmem_resp = 1'b0;
         mem_cnt   = 0;
      end
   end

   // Cache agents: hold a request level until its resp is seen, then take the next one.
   typedef struct {
      logic     rd;
      logic     wr;
      lc3b_word addr;
      lc3b_line wdata;
   } dreq_t;

   lc3b_word i_q[$];
   dreq_t    d_q[$];
   bit       i_seen = 1'b0;
   bit       d_seen = 1'b0;

   initial forever begin
      @(posedge clk); #2;
      if (i_read && i_seen) begin
         i_q.delete(0);
         i_seen = 1'b0;
         i_read = 1'b0;
      end
      if (!i_read && i_q.size() > 0) begin
         i_read    = 1'b1;
         i_address = i_q[0];
      end
   end

   initial forever begin
      @(posedge clk); #2;
      if ((d_read || d_write) && d_seen) begin
         d_q.delete(0);
         d_seen  = 1'b0;
         d_read  = 1'b0;
         d_write = 1'b0;
      end
      if (!(d_read || d_write) && d_q.size() > 0) begin
         d_read    = d_q[0].rd;
         d_write   = d_q[0].wr;
         d_address = d_q[0].addr;
         d_wdata   = d_q[0].wdata;
      end
   end

   // Transaction-level model: who owns memory (0 none, 1 icache, 2 dcache),
   // what it asked for, and who wins the next tie.
   int       m_who = 0;
   int       m_tie;
   int       w;
   lc3b_word m_addr;
   logic     m_wr;
   lc3b_line m_wdata;
   int       grants[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_who = 0;
         m_tie = FIRST_D ? 2 : 1;
      end else if (m_who != 0) begin
         if (pmem_resp) m_who = 0;
      end else begin
         w = 0;
         if (i_read && (d_read || d_write)) w = m_tie;
         else if (i_read)                   w = 1;
         else if (d_read || d_write)        w = 2;
         if (w != 0) begin
            m_who = w;
            m_tie = (w == 1) ? 2 : 1;
            grants.push_back(w);
            if (w == 1) begin
               m_addr = i_address;
               m_wr   = 1'b0;
            end else begin
               m_addr  = d_address;
               m_wr    = d_write;
               m_wdata = d_wdata;
            end
         end
      end
   end

   int   i_cnt = 0;
   int   d_cnt = 0;
   int   resp_log[$];
   logic exp_i, exp_d;

   always @(negedge clk) begin
      if (i_resp === 1'b1) begin i_seen = 1'b1; i_cnt++; resp_log.push_back(1); end
      if (d_resp === 1'b1) begin d_seen = 1'b1; d_cnt++; resp_log.push_back(2); end
      if (chk_en) begin
         exp_i = rst_n && (m_who == 1) && pmem_resp;
         exp_d = rst_n && (m_who == 2) && pmem_resp;
         chk("pmem_read", pmem_read, (m_who != 0) && !m_wr);
         chk("pmem_write", pmem_write, (m_who != 0) && m_wr);
         if (m_who != 0) chk("pmem_address", pmem_address, m_addr);
         if (m_who == 2 && m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
         chk("i_resp", i_resp, exp_i);
         chk("d_resp", d_resp, exp_d);
         if (exp_i) chk("i_rdata", i_rdata, pmem_rdata);
         if (exp_d) chk("d_rdata", d_rdata, pmem_rdata);
      end
   end

   function automatic logic sel(input int which);
      case (which)
         0:       return i_read;
         1:       return pmem_read;
         2:       return i_resp;
         3:       return d_resp;
         default: return pmem_write;
      endcase
   endfunction

   task automatic wait_for(input int which, output int c);
      c = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (sel(which) === 1'b1) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         total++;
         bad++;
         $display("FAIL wait_%0d: got no event within 100 cycles want event", which);
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (i_q.size() == 0 && d_q.size() == 0 && !i_read && !d_read && !d_write && m_who == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_reached", ok, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int c0, c1, c2, ic, dc;
      rst_n = 1'b0; i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
      pmem_resp = 1'b0; pmem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_pmem_read", pmem_read, 1'b0);
      chk("rst_pmem_write", pmem_write, 1'b0);
      chk("rst_i_resp", i_resp, 1'b0);
      chk("rst_d_resp", d_resp, 1'b0);
      chk("rst_pmem_address", pmem_address, 16'h0);
      chk("rst_pmem_wdata", pmem_wdata, 128'h0);
      chk("rst_i_rdata", i_rdata, 128'h0);
      chk("rst_d_rdata", d_rdata, 128'h0);
      rst_n = 1'b1;

      // Single icache read, memory latency 3.
      @(negedge clk);
      mem_lat = 3; ic = i_cnt; dc = d_cnt;
      i_q.push_back(16'h1230);
      wait_for(0, c0);
      wait_for(1, c1);
      wait_for(2, c2);
      chk("i_cmd_delay", c1 - c0, 1);
      chk("i_resp_delay", c2 - c0, 4);
      chk("i_rdata_line", i_rdata, line_of(16'h1230));
      @(negedge clk);
      chk("i_resp_one_pulse", i_resp, 1'b0);
      chk("i_resp_count", i_cnt - ic, 1);
      chk("d_resp_silent", d_cnt - dc, 0);
      wait_idle();

      // dcache write; address changes mid-service must not leak through.
      dc = d_cnt;
      d_q.push_back('{1'b0, 1'b1, 16'h4000, {16{8'hA5}}});
      wait_for(4, c1);
      d_address = 16'h5555;
      chk("wr_addr_start", pmem_address, 16'h4000);
      chk("wr_wdata_start", pmem_wdata, {16{8'hA5}});
      chk("wr_no_read", pmem_read, 1'b0);
      wait_for(3, c2);
      chk("wr_addr_held", pmem_address, 16'h4000);
      chk("wr_wdata_held", pmem_wdata, {16{8'hA5}});
      chk("wr_cmd_at_resp", pmem_write, 1'b1);
      @(negedge clk);
      chk("d_resp_one_pulse", d_resp, 1'b0);
      chk("d_resp_count", d_cnt - dc, 1);
      wait_idle();

      // d_read and d_write together behave as a write.
      d_q.push_back('{1'b1, 1'b1, 16'h0777, line_of(16'h0ABC)});
      wait_for(4, c1);
      chk("rw_no_read", pmem_read, 1'b0);
      chk("rw_write", pmem_write, 1'b1);
      chk("rw_addr", pmem_address, 16'h0777);
      wait_for(3, c2);
      wait_idle();

      // Short latencies and a dcache request arriving while icache is served.
      mem_lat = 0;
      i_q.push_back(16'h0100);
      wait_idle();
      mem_lat = 1;
      resp_log.delete();
      i_q.push_back(16'h0200);
      wait_for(1, c1);
      d_q.push_back('{1'b1, 1'b0, 16'h0300, '0});
      wait_idle();
      chk("stagger_count", resp_log.size(), 2);
      chk("stagger_first_i", (resp_log.size() > 0) ? resp_log[0] : 0, 1);
      chk("stagger_then_d", (resp_log.size() > 1) ? resp_log[1] : 0, 2);

      // After reset, continuous ties alternate starting with dcache.
      do_reset();
      mem_lat = 2;
      grants.delete();
      resp_log.delete();
      for (int k = 0; k < 3; k++) begin
         i_q.push_back(16'h1000 + 16'(k * 16));
         d_q.push_back('{1'b1, 1'b0, 16'h2000 + 16'(k * 16), '0});
      end
      wait_idle();
      chk("rr_count", resp_log.size(), 6);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr_dut_%0d", k), (k < resp_log.size()) ? resp_log[k] : 0, (k % 2 == 0) ? 2 : 1);
         chk($sformatf("rr_model_%0d", k), (k < grants.size()) ? grants[k] : 0, (k % 2 == 0) ? 2 : 1);
      end

      // Reset landing on the cycle memory responds to an icache read.
      mem_lat = 3;
      ic = i_cnt;
      i_q.push_back(16'h3030);
      wait_for(1, c1);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #2;
         if (pmem_resp) break;
      end
      chk("rst_resp_pending", pmem_resp, 1'b1);
      i_q.delete();
      i_read = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      chk("rst_no_i_resp", i_resp, 1'b0);
      @(negedge clk);
      chk("rst_pmem_read_low", pmem_read, 1'b0);
      chk("rst_pmem_write_low", pmem_write, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_i_resp_count", i_cnt - ic, 0);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
